fifo_csr_master: RTL and testbench

//   Avalon-MM master that drives the fifo_csr slave from the initiator side. Polls the
//   CSR status word, then pushes stream data into the FIFO (write to address 2) or drains
//   it (read from address 1) to an output stream. Sits between producer/consumer logic
//   and the CSR-mapped circular FIFO, so the datapath needs no software intervention.

---
 rtl/fifo_csr_master.sv | 151 +++++++++++++++
 tb/tb_fifo_csr_master.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_csr_master.sv
// Avalon-MM master for the fifo_csr slave: polls the STATUS word, then pushes a
// producer word into the FIFO or pops one out to a single-entry sink buffer.
module fifo_csr_master #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 src_valid,
  input  logic [WIDTH-1:0]     src_data,
  output logic                 src_ready,
  output logic                 snk_valid,
  output logic [WIDTH-1:0]     snk_data,
  input  logic                 snk_ready,
  output logic [1:0]           avalon_address,
  output logic                 avalon_read,
  output logic                 avalon_write,
  output logic [WIDTH-1:0]     avalon_writedata,
  input  logic [WIDTH-1:0]     avalon_readdata,
  output logic [CNT_WIDTH-1:0] push_count,
  output logic [CNT_WIDTH-1:0] pop_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STAT_RD,
    S_STAT_WT,
    S_WR,
    S_RD,
    S_RD_WT
  } state_e;

  localparam logic [1:0] ADDR_STATUS     = 2'd0;
  localparam logic [1:0] ADDR_FIFO_READ  = 2'd1;
  localparam logic [1:0] ADDR_FIFO_WRITE = 2'd2;

  state_e               state_q, state_d;
  logic                 read_q, read_d;
  logic                 write_q, write_d;
  logic [1:0]           address_q, address_d;
  logic [WIDTH-1:0]     writedata_q, writedata_d;
  logic                 src_ready_q, src_ready_d;
  logic                 snk_valid_q, snk_valid_d;
  logic [WIDTH-1:0]     snk_data_q, snk_data_d;
  logic [CNT_WIDTH-1:0] push_count_q, push_count_d;
  logic [CNT_WIDTH-1:0] pop_count_q, pop_count_d;

  logic status_full;
  logic status_empty;

  assign status_full  = avalon_readdata[0];
  assign status_empty = avalon_readdata[1];

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d      = state_q;
    snk_valid_d  = snk_valid_q;
    snk_data_d   = snk_data_q;
    push_count_d = push_count_q;
    pop_count_d  = pop_count_q;

    if (snk_valid_q && snk_ready) begin
      snk_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (enable && (src_valid || !snk_valid_q)) begin
          state_d = S_STAT_RD;
        end
      end
      S_STAT_RD: state_d = S_STAT_WT;
      S_STAT_WT: begin
        // Push wins over pop; an illegal full+empty status blocks both.
        if (src_valid && !status_full) begin
          state_d = S_WR;
        end else if (!snk_valid_q && !status_empty) begin
          state_d = S_RD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WR: begin
        push_count_d = push_count_q + 1'b1;
        state_d      = S_IDLE;
      end
      S_RD: state_d = S_RD_WT;
      S_RD_WT: begin
        snk_data_d  = avalon_readdata;
        snk_valid_d = 1'b1;
        pop_count_d = pop_count_q + 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Bus outputs are registered off the next state so each strobe lines up
    // exactly with the cycle its state is occupied.
    read_d      = (state_d == S_STAT_RD) || (state_d == S_RD);
    write_d     = (state_d == S_WR);
    src_ready_d = (state_d == S_WR);
    writedata_d = (state_d == S_WR) ? src_data : '0;
    case (state_d)
      S_STAT_RD: address_d = ADDR_STATUS;
      S_RD:      address_d = ADDR_FIFO_READ;
      S_WR:      address_d = ADDR_FIFO_WRITE;
      default:   address_d = ADDR_STATUS;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      address_q    <= ADDR_STATUS;
      writedata_q  <= '0;
      src_ready_q  <= 1'b0;
      snk_valid_q  <= 1'b0;
      snk_data_q   <= '0;
      push_count_q <= '0;
      pop_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      read_q       <= read_d;
      write_q      <= write_d;
      address_q    <= address_d;
      writedata_q  <= writedata_d;
      src_ready_q  <= src_ready_d;
      snk_valid_q  <= snk_valid_d;
      snk_data_q   <= snk_data_d;
      push_count_q <= push_count_d;
      pop_count_q  <= pop_count_d;
    end
  end

  assign avalon_read      = read_q;
  assign avalon_write     = write_q;
  assign avalon_address   = address_q;
  assign avalon_writedata = writedata_q;
  assign src_ready        = src_ready_q;
  assign snk_valid        = snk_valid_q;
  assign snk_data         = snk_data_q;
  assign push_count       = push_count_q;
  assign pop_count        = pop_count_q;

endmodule

// File: tb/tb_fifo_csr_master.sv
// Directed bench for fifo_csr_master; a small reactive CSR slave returns a
// bench-chosen status word or FIFO word one cycle after each read strobe.
module tb_fifo_csr_master;

  localparam int WIDTH     = 8;
  localparam int CNT_WIDTH = 8;

  logic                 clk;
  logic                 reset;
  logic                 enable;
  logic                 src_valid;
  logic [WIDTH-1:0]     src_data;
  logic                 src_ready;
  logic                 snk_valid;
  logic [WIDTH-1:0]     snk_data;
  logic                 snk_ready;
  logic [1:0]           avalon_address;
  logic                 avalon_read;
  logic                 avalon_write;
  logic [WIDTH-1:0]     avalon_writedata;
  logic [WIDTH-1:0]     avalon_readdata;
  logic [CNT_WIDTH-1:0] push_count;
  logic [CNT_WIDTH-1:0] pop_count;

  logic [WIDTH-1:0] status_word = '0;
  logic [WIDTH-1:0] fifo_word   = '0;
  int stat_reads = 0;
  int fifo_reads = 0;
  int writes     = 0;
  int proto_err  = 0;

  int tests = 0;
  int fails = 0;

  fifo_csr_master #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .src_valid        (src_valid),
    .src_data         (src_data),
    .src_ready        (src_ready),
    .snk_valid        (snk_valid),
    .snk_data         (snk_data),
    .snk_ready        (snk_ready),
    .avalon_address   (avalon_address),
    .avalon_read      (avalon_read),
    .avalon_write     (avalon_write),
    .avalon_writedata (avalon_writedata),
    .avalon_readdata  (avalon_readdata),
    .push_count       (push_count),
    .pop_count        (pop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial avalon_readdata = '0;

  // Slave model plus bus-rule monitor.
  always @(posedge clk) begin
    if (avalon_read) begin
      avalon_readdata <= (avalon_address == 2'd0) ? status_word : fifo_word;
      if (avalon_address == 2'd0) stat_reads <= stat_reads + 1;
      if (avalon_address == 2'd1) fifo_reads <= fifo_reads + 1;
    end
    if (avalon_write) writes <= writes + 1;
    if (avalon_read && avalon_write) proto_err <= proto_err + 1;
    if (!avalon_write && avalon_writedata != '0) proto_err <= proto_err + 1;
    if (!avalon_read && !avalon_write && avalon_address != 2'd0) proto_err <= proto_err + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic quiesce();
    enable    = 1'b0;
    src_valid = 1'b0;
    repeat (6) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int r0;
    bit got;

    // Reset held with a pending producer word: nothing may move.
    reset     = 1'b0;
    enable    = 1'b1;
    src_valid = 1'b1;
    src_data  = 8'h5A;
    snk_ready = 1'b0;
    status_word = 8'h02;
    tick();
    check("rst_snk_valid", 32'(snk_valid), 0);
    check("rst_snk_data", 32'(snk_data), 0);
    check("rst_push_count", 32'(push_count), 0);
    check("rst_pop_count", 32'(pop_count), 0);
    check("rst_src_ready", 32'(src_ready), 0);
    check("rst_addr", 32'(avalon_address), 0);
    check("rst_wdata", 32'(avalon_writedata), 0);
    repeat (4) begin
      tick();
      check("rst_no_strobe", 32'({avalon_read, avalon_write}), 0);
    end
    enable    = 1'b0;
    src_valid = 1'b0;
    reset     = 1'b1;
    tick();
    check("idle_after_rst", 32'({avalon_read, avalon_write}), 0);

    // Push 0xA5; enable dropped mid-sequence must not abort it.
    status_word = 8'h02;
    src_valid   = 1'b1;
    src_data    = 8'hA5;
    enable      = 1'b1;
    tick();
    check("push_c1_stat_rd", 32'({avalon_read, avalon_write, avalon_address}), 'b1000);
    enable = 1'b0;
    tick();
    check("push_c2_quiet", 32'({avalon_read, avalon_write}), 0);
    tick();
    check("push_c3_write", 32'({avalon_read, avalon_write, avalon_address}), 'b0110);
    check("push_c3_wdata", 32'(avalon_writedata), 'hA5);
    check("push_c3_src_ready", 32'(src_ready), 1);
    src_valid = 1'b0;
    tick();
    check("push_c4_src_ready_low", 32'({src_ready, avalon_write}), 0);
    check("push_count_1", 32'(push_count), 1);
    tick();
    check("push_no_restart", 32'(avalon_read), 0);

    // Pop 0x3C, then hold the sink off.
    status_word = 8'h00;
    fifo_word   = 8'h3C;
    enable      = 1'b1;
    tick();
    check("pop_c1_stat_rd", 32'({avalon_read, avalon_address}), 'b100);
    tick();
    tick();
    check("pop_c3_fifo_rd", 32'({avalon_read, avalon_write, avalon_address}), 'b1001);
    tick();
    check("pop_c4_quiet", 32'(avalon_read), 0);
    tick();
    check("pop_snk_valid", 32'(snk_valid), 1);
    check("pop_snk_data", 32'(snk_data), 'h3C);
    check("pop_count_1", 32'(pop_count), 1);
    check("pop_fifo_reads", 32'(fifo_reads), 1);
    s0 = stat_reads;
    repeat (10) tick();
    check("hold_no_poll", 32'(stat_reads), 32'(s0));
    check("hold_snk_valid", 32'(snk_valid), 1);
    check("hold_snk_data", 32'(snk_data), 'h3C);

    // FIFO full while the sink is held: STATUS polls only.
    status_word = 8'h01;
    src_valid   = 1'b1;
    src_data    = 8'h11;
    repeat (20) tick();
    check("full_no_write", 32'(writes), 1);
    check("full_no_fifo_read", 32'(fifo_reads), 1);
    check("full_polls", 32'(stat_reads > s0 + 3), 1);
    quiesce();
    snk_ready = 1'b1;
    tick();
    check("drain_snk_valid", 32'(snk_valid), 0);
    snk_ready = 1'b0;

    // FIFO empty with an empty sink: no FIFO_READ.
    status_word = 8'h02;
    enable      = 1'b1;
    repeat (20) tick();
    check("empty_no_fifo_read", 32'(fifo_reads), 1);
    check("empty_snk_valid", 32'(snk_valid), 0);
    quiesce();

    // Illegal full+empty status: nothing issued either way.
    status_word = 8'h03;
    src_valid   = 1'b1;
    enable      = 1'b1;
    repeat (20) tick();
    check("illegal_no_write", 32'(writes), 1);
    check("illegal_no_fifo_read", 32'(fifo_reads), 1);
    quiesce();

    // src_valid withdrawn during STAT_RD: no write.
    status_word = 8'h02;
    src_valid   = 1'b1;
    enable      = 1'b1;
    tick();
    check("drop_c1_stat_rd", 32'(avalon_read), 1);
    src_valid = 1'b0;
    enable    = 1'b0;
    repeat (4) tick();
    check("drop_no_write", 32'(writes), 1);
    check("drop_push_count", 32'(push_count), 1);

    // Push priority, then a pop on the following sequence.
    status_word = 8'h00;
    fifo_word   = 8'h81;
    src_valid   = 1'b1;
    src_data    = 8'hC3;
    enable      = 1'b1;
    repeat (3) tick();
    check("prio_write_first", 32'({avalon_read, avalon_write, avalon_address}), 'b0110);
    check("prio_wdata", 32'(avalon_writedata), 'hC3);
    src_valid = 1'b0;
    repeat (4) tick();
    check("b2b_fifo_rd", 32'({avalon_read, avalon_address}), 'b101);
    repeat (2) tick();
    check("b2b_snk_valid", 32'(snk_valid), 1);
    check("b2b_snk_data", 32'(snk_data), 'h81);
    check("b2b_pop_count", 32'(pop_count), 2);
    check("b2b_push_count", 32'(push_count), 2);
    enable    = 1'b0;
    snk_ready = 1'b1;
    tick();
    snk_ready = 1'b0;
    repeat (4) tick();

    // 254 more pushes take the 8-bit counter from 2 through 255 to 0.
    status_word = 8'h02;
    enable      = 1'b1;
    for (int i = 0; i < 254; i++) begin
      src_data  = 8'(i);
      src_valid = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 8 && !got; k++) begin
        tick();
        got = src_ready;
      end
      check("wrap_handshake", 32'(src_ready), 1);
      check("wrap_wdata", 32'(avalon_writedata), i);
      if (i == 253) check("wrap_pre_count", 32'(push_count), 255);
    end
    src_valid = 1'b0;
    enable    = 1'b0;
    tick();
    check("wrap_push_count_0", 32'(push_count), 0);
    check("wrap_no_pop", 32'(snk_valid), 0);
    repeat (4) tick();

    // Fresh reset, then reset again while the popped word is in flight.
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("rst2_counts", 32'({push_count, pop_count}), 0);
    status_word = 8'h00;
    fifo_word   = 8'h77;
    enable      = 1'b1;
    repeat (3) tick();
    check("rst_rd_strobe", 32'({avalon_read, avalon_address}), 'b101);
    tick();
    r0 = fifo_reads;
    reset = 1'b0;
    #1;
    check("rst_rdwt_snk_valid", 32'(snk_valid), 0);
    check("rst_rdwt_pop_count", 32'(pop_count), 0);
    check("rst_rdwt_strobes", 32'({avalon_read, avalon_write}), 0);
    enable = 1'b0;
    tick();
    reset = 1'b1;
    repeat (3) tick();
    check("rst_lost_snk_valid", 32'(snk_valid), 0);
    check("rst_lost_snk_data", 32'(snk_data), 0);
    check("rst_lost_pop_count", 32'(pop_count), 0);
    check("rst_no_more_reads", 32'(fifo_reads), 32'(r0));

    // Reset during a live STATUS strobe drops it immediately.
    enable = 1'b1;
    tick();
    check("rst2_stat_rd", 32'(avalon_read), 1);
    reset = 1'b0;
    #1;
    check("rst2_strobe_drop", 32'(avalon_read), 0);
    enable = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    check("bus_rules", 32'(proto_err), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
